local_ctrl_fc: RTL and testbench



---
 rtl/local_ctrl_pkg.sv | 19 +
 rtl/local_ctrl_dly.sv | 44 ++++
 rtl/local_ctrl_fc.sv | 210 +++++++++++++++++++++
 tb/tb_local_ctrl_fc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_ctrl_pkg.sv
// local_ctrl_pkg: shared types and constants for the layer controller.
package local_ctrl_pkg;

  // Controller phases; the state register and the output registers are
  // loaded from the same next-state decision, so the state seen in a cycle
  // is the phase whose strobes are visible in that same cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    SAVE  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Latency of the x-buffer / weight-ROM read, in cycles.
  localparam int RD_LAT = 1;

endpackage

// File: rtl/local_ctrl_dly.sv
// local_ctrl_dly: aligns the MAC enable/clear strobes with returning read data.
// A DEPTH-stage shift register delays rd_en and the first-term flag.
module local_ctrl_dly #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rd_en,
  input  logic i_first,
  output logic o_mac_en,
  output logic o_mac_clear
);

  logic [DEPTH-1:0] r_en_sr;
  logic [DEPTH-1:0] r_clr_sr;

  if (DEPTH == 1) begin : g_one
    // Single-stage delay of the read strobe and the first-term flag.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_en_sr  <= '0;
        r_clr_sr <= '0;
      end else begin
        r_en_sr  <= i_rd_en;
        r_clr_sr <= i_first & i_rd_en;
      end
    end
  end else begin : g_multi
    // Multi-stage delay of the read strobe and the first-term flag.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_en_sr  <= '0;
        r_clr_sr <= '0;
      end else begin
        r_en_sr  <= {r_en_sr[DEPTH-2:0], i_rd_en};
        r_clr_sr <= {r_clr_sr[DEPTH-2:0], i_first & i_rd_en};
      end
    end
  end

  assign o_mac_en    = r_en_sr[DEPTH-1];
  assign o_mac_clear = r_clr_sr[DEPTH-1];

endmodule

// File: rtl/local_ctrl_fc.sv
// local_ctrl_fc: sequences NUM_NEURONS dot products of VEC_LEN terms for one
// fully-connected layer, driving reads, MAC strobes and temp-buffer writes.
// Optional macro LOCAL_CTRL_STALL_EN adds stall_i, honoured only at neuron
// boundaries (NEXT) and on the IDLE->RUN transition.
module local_ctrl_fc
  import local_ctrl_pkg::*;
#(
  parameter  int VEC_LEN     = 32,
  parameter  int NUM_NEURONS = 10,
  parameter  int SAVE_LAT    = 2,
  localparam int X_AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
  localparam int N_AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int W_AW = (VEC_LEN * NUM_NEURONS > 1) ? $clog2(VEC_LEN * NUM_NEURONS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
`ifdef LOCAL_CTRL_STALL_EN
  input  logic            stall_i,
`endif
  output logic            busy_o,
  output logic [X_AW-1:0] x_addr_o,
  output logic [W_AW-1:0] w_addr_o,
  output logic            rd_en_o,
  output logic            mac_en_o,
  output logic            mac_clear_o,
  output logic            mac_valid_o,
  output logic            temp_wr_o,
  output logic [N_AW-1:0] temp_addr_o,
  output logic            done_o
);

  // Counter for the DRAIN and SAVE waits; wide enough for either.
  localparam int CNT_W = $clog2(SAVE_LAT + RD_LAT + 1);

  localparam logic [X_AW-1:0]  X_LAST     = X_AW'(VEC_LEN - 1);
  localparam logic [N_AW-1:0]  N_LAST     = N_AW'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] SAVE_LAST  = CNT_W'((SAVE_LAT > 0) ? SAVE_LAT - 1 : 0);
  localparam logic [X_AW-1:0]  X_ONE      = X_AW'(1);
  localparam logic [W_AW-1:0]  W_ONE      = W_AW'(1);
  localparam logic [N_AW-1:0]  N_ONE      = N_AW'(1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  state_t            r_state, w_state;
  logic [X_AW-1:0]   r_k, w_k;
  logic [W_AW-1:0]   r_w, w_w;
  logic [N_AW-1:0]   r_n, w_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_rd_en, w_rd_en;
  logic              r_first, w_first;
  logic              r_valid, w_valid;
  logic              r_wr, w_wr;
  logic              r_done, w_done;
  logic              r_busy, w_busy;
  logic              w_stall;
  logic              w_mac_en;
  logic              w_mac_clear;

`ifdef LOCAL_CTRL_STALL_EN
  assign w_stall = stall_i;
`else
  assign w_stall = 1'b0;
`endif

  // Next-state, counter and strobe decisions; strobes default low.
  always_comb begin
    w_state = r_state;
    w_k     = r_k;
    w_w     = r_w;
    w_n     = r_n;
    w_cnt   = r_cnt;
    w_rd_en = 1'b0;
    w_first = 1'b0;
    w_valid = 1'b0;
    w_wr    = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_k   = '0;
        w_w   = '0;
        w_n   = '0;
        w_cnt = '0;
        if (start_i && !w_stall) begin
          w_state = RUN;
          w_rd_en = 1'b1;
          w_first = 1'b1;
        end else begin
          w_state = IDLE;
        end
      end
      RUN: begin
        if (r_k == X_LAST) begin
          w_state = DRAIN;
          w_cnt   = '0;
        end else begin
          w_k     = r_k + X_ONE;
          w_w     = r_w + W_ONE;
          w_rd_en = 1'b1;
        end
      end
      DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_valid = 1'b1;
          w_cnt   = '0;
          // With no save latency the write coincides with mac_valid.
          if (SAVE_LAT == 0) begin
            w_state = NEXT;
            w_wr    = 1'b1;
          end else begin
            w_state = SAVE;
          end
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      SAVE: begin
        if (r_cnt == SAVE_LAST) begin
          w_state = NEXT;
          w_wr    = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      NEXT: begin
        if (w_stall) begin
          w_state = NEXT;
        end else if (r_n == N_LAST) begin
          w_state = DONE;
          w_done  = 1'b1;
        end else begin
          w_state = RUN;
          w_rd_en = 1'b1;
          w_first = 1'b1;
          w_k     = '0;
          w_w     = r_w + W_ONE;
          w_n     = r_n + N_ONE;
        end
      end
      DONE: begin
        w_state = IDLE;
        w_k     = '0;
        w_w     = '0;
        w_n     = '0;
        w_cnt   = '0;
      end
      default: begin
        w_state = IDLE;
        w_k     = '0;
        w_w     = '0;
        w_n     = '0;
        w_cnt   = '0;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  // State, counters and registered strobes; reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_w     <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_rd_en <= 1'b0;
      r_first <= 1'b0;
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_k     <= w_k;
      r_w     <= w_w;
      r_n     <= w_n;
      r_cnt   <= w_cnt;
      r_rd_en <= w_rd_en;
      r_first <= w_first;
      r_valid <= w_valid;
      r_wr    <= w_wr;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  local_ctrl_dly #(
    .DEPTH (RD_LAT)
  ) u_dly (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_rd_en     (r_rd_en),
    .i_first     (r_first),
    .o_mac_en    (w_mac_en),
    .o_mac_clear (w_mac_clear)
  );

  assign busy_o      = r_busy;
  assign x_addr_o    = r_k;
  assign w_addr_o    = r_w;
  assign rd_en_o     = r_rd_en;
  assign mac_en_o    = w_mac_en;
  assign mac_clear_o = w_mac_clear;
  assign mac_valid_o = r_valid;
  assign temp_wr_o   = r_wr;
  assign temp_addr_o = r_n;
  assign done_o      = r_done;

endmodule

// File: tb/tb_local_ctrl_fc.sv
// tb_local_ctrl_fc: scoreboard bench for local_ctrl_fc. Two instances:
// default parameters and the minimal VEC_LEN=2/NUM_NEURONS=1/SAVE_LAT=0 case.
// With LOCAL_CTRL_STALL_EN defined, a neuron-boundary stall is also exercised.
module tb_local_ctrl_fc;

  localparam int VL0 = 32, NN0 = 10, SL0 = 2;
  localparam int VL1 = 2,  NN1 = 1,  SL1 = 0;

  localparam int K_RD = 0, K_EN = 1, K_CLR = 2, K_VAL = 3, K_WR = 4, K_DONE = 5;

  typedef struct {
    int c;
    int a;
    int b;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 0 signals
  logic       rst0, start0, stall0;
  logic       busy0, rd0, en0, clr0, val0, wr0, done0;
  logic [4:0] x0;
  logic [8:0] w0;
  logic [3:0] t0;
  // DUT 1 signals
  logic       rst1, start1, stall1;
  logic       busy1, rd1, en1, clr1, val1, wr1, done1;
  logic [0:0] x1, w1, t1;

  local_ctrl_fc #(.VEC_LEN(VL0), .NUM_NEURONS(NN0), .SAVE_LAT(SL0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .start_i(start0),
`ifdef LOCAL_CTRL_STALL_EN
    .stall_i(stall0),
`endif
    .busy_o(busy0), .x_addr_o(x0), .w_addr_o(w0), .rd_en_o(rd0),
    .mac_en_o(en0), .mac_clear_o(clr0), .mac_valid_o(val0),
    .temp_wr_o(wr0), .temp_addr_o(t0), .done_o(done0)
  );

  local_ctrl_fc #(.VEC_LEN(VL1), .NUM_NEURONS(NN1), .SAVE_LAT(SL1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .start_i(start1),
`ifdef LOCAL_CTRL_STALL_EN
    .stall_i(stall1),
`endif
    .busy_o(busy1), .x_addr_o(x1), .w_addr_o(w1), .rd_en_o(rd1),
    .mac_en_o(en1), .mac_clear_o(clr1), .mac_valid_o(val1),
    .temp_wr_o(wr1), .temp_addr_o(t1), .done_o(done1)
  );

  // Reference model state
  int  vl [2] = '{VL0, VL1};
  int  nn [2] = '{NN0, NN1};
  int  sl [2] = '{SL0, SL1};
  bit  have_pass [2] = '{1'b0, 1'b0};
  int  pass_t0  [2] = '{0, 0};
  int  pass_end [2] = '{0, 0};
  int  stall_n  [2] = '{-1, -1};
  int  stall_len[2] = '{0, 0};
  int  plan_sn  [2] = '{-1, -1};
  int  plan_len [2] = '{0, 0};
  int  last_x   [2] = '{0, 0};
  int  last_w   [2] = '{0, 0};
  ev_t evq [2][6][$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int per(input int d);
    return vl[d] + sl[d] + 2;
  endfunction

  // First read cycle of neuron n in the current pass.
  function automatic int nt0(input int d, input int n);
    int extra;
    extra = (stall_n[d] >= 0 && n > stall_n[d]) ? stall_len[d] : 0;
    return pass_t0[d] + n * per(d) + extra;
  endfunction

  function automatic bit busy_exp(input int d, input int c);
    return have_pass[d] && c >= pass_t0[d] && c <= pass_end[d];
  endfunction

  function automatic int tmp_exp(input int d, input int c);
    int r;
    r = 0;
    for (int n = 1; n < nn[d]; n++) if (nt0(d, n) <= c) r = n;
    return r;
  endfunction

  function automatic bit stall_window(input int d, input int c);
    int s;
    if (!have_pass[d] || stall_n[d] < 0 || c > pass_end[d]) return 1'b0;
    s = nt0(d, stall_n[d]) + vl[d] + 1 + sl[d];
    return c >= s && c < s + stall_len[d];
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_RD:    return "rd_en";
      K_EN:    return "mac_en";
      K_CLR:   return "mac_clear";
      K_VAL:   return "mac_valid";
      K_WR:    return "temp_wr";
      default: return "done";
    endcase
  endfunction

  task automatic push_ev(input int d, input int k, input int c, input int a, input int b);
    ev_t e;
    e.c = c; e.a = a; e.b = b;
    evq[d][k].push_back(e);
  endtask

  // Expected responses of a whole pass, from the timing rules.
  task automatic start_pass(input int d, input int t, input int sn, input int slen);
    int s;
    have_pass[d] = 1'b1;
    pass_t0[d]   = t;
    stall_n[d]   = sn;
    stall_len[d] = slen;
    for (int n = 0; n < nn[d]; n++) begin
      s = nt0(d, n);
      for (int k = 0; k < vl[d]; k++) begin
        push_ev(d, K_RD, s + k, k, n * vl[d] + k);
        push_ev(d, K_EN, s + k + 1, 0, 0);
      end
      push_ev(d, K_CLR, s + 1, 0, 0);
      push_ev(d, K_VAL, s + vl[d] + 1, 0, 0);
      push_ev(d, K_WR, s + vl[d] + 1 + sl[d], n, 0);
    end
    pass_end[d] = nt0(d, nn[d] - 1) + per(d);
    push_ev(d, K_DONE, pass_end[d], 0, 0);
  endtask

  // Drive one cycle of stimulus into DUT d and update the model.
  task automatic cycle_drive(input int d, input bit st);
    int c;
    bit stl;
    c   = cyc;
    stl = stall_window(d, c);
    if (d == 0) begin
      start0 = st;
`ifdef LOCAL_CTRL_STALL_EN
      stall0 = stl;
`endif
    end else begin
      start1 = st;
    end
    if (st && !stl && !busy_exp(d, c)) begin
      start_pass(d, c + 1, plan_sn[d], plan_len[d]);
      plan_sn[d] = -1;
    end
    @(negedge clk);
  endtask

  // One-cycle reset of DUT d; expected events after it are discarded.
  task automatic do_reset(input int d);
    int c;
    c = cyc;
    if (d == 0) begin rst0 = 1'b1; start0 = 1'b0; end
    else begin rst1 = 1'b1; start1 = 1'b0; end
    if (have_pass[d] && pass_end[d] > c) pass_end[d] = c;
    for (int k = 0; k < 6; k++)
      while (evq[d][k].size() > 0 && evq[d][k][$].c > c) void'(evq[d][k].pop_back());
    @(negedge clk);
    if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
  endtask

  task automatic chk(input int d, input string nm, input bit ok, input int got, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%0d required=%0d", nm, d, cyc, got, req);
  endtask

  // Pop and compare one strobe kind; -1 stands for "no strobe".
  task automatic check_kind(input int d, input int k, input int strobe, input int a, input int b,
                            output bit hit, output int ea, output int eb);
    ev_t e;
    hit = 1'b0; ea = 0; eb = 0;
    while (evq[d][k].size() > 0 && evq[d][k][0].c < cyc) begin
      e = evq[d][k].pop_front();
      chk(d, {kname(k), "_missed"}, 1'b0, -1, e.c);
    end
    if (evq[d][k].size() > 0 && evq[d][k][0].c == cyc) begin
      e   = evq[d][k].pop_front();
      hit = 1'b1; ea = e.a; eb = e.b;
      chk(d, kname(k), strobe == 1 && a == e.a && b == e.b,
          (strobe == 1) ? a * 1000 + b : -1, e.a * 1000 + e.b);
    end else if (strobe != 0) begin
      chk(d, kname(k), 1'b0, a * 1000 + b, -1);
    end
  endtask

  task automatic check_dut(input int d, input int rd, input int en, input int clr, input int val,
                           input int wr, input int dn, input int bz, input int x, input int w,
                           input int t);
    bit be, h, rd_due;
    int ea, eb;
    be     = busy_exp(d, cyc);
    rd_due = evq[d][K_RD].size() > 0 && evq[d][K_RD][0].c == cyc;
    chk(d, "busy", bz == int'(be), bz, int'(be));
    if (!be) begin
      chk(d, "idle_zero", (rd | en | clr | val | wr | dn) == 0 && x == 0 && w == 0 && t == 0,
          rd + en + clr + val + wr + dn + x + w + t, 0);
    end else begin
      if (!rd_due)
        chk(d, "addr_hold", x == last_x[d] && w == last_w[d], x * 1000 + w,
            last_x[d] * 1000 + last_w[d]);
      chk(d, "temp_addr", t == tmp_exp(d, cyc), t, tmp_exp(d, cyc));
    end
    check_kind(d, K_RD, rd, x, w, h, ea, eb);
    if (h) begin last_x[d] = ea; last_w[d] = eb; end
    check_kind(d, K_EN,   en,  0, 0, h, ea, eb);
    check_kind(d, K_CLR,  clr, 0, 0, h, ea, eb);
    check_kind(d, K_VAL,  val, 0, 0, h, ea, eb);
    check_kind(d, K_WR,   wr,  t, 0, h, ea, eb);
    check_kind(d, K_DONE, dn,  0, 0, h, ea, eb);
    if ((val | wr) != 0) chk(d, "strobe_excl", en == 0, en, 0);
  endtask

  // Monitor: compares every DUT output against the scoreboard each cycle.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check_dut(0, int'(rd0), int'(en0), int'(clr0), int'(val0), int'(wr0), int'(done0),
                int'(busy0), int'(x0), int'(w0), int'(t0));
      check_dut(1, int'(rd1), int'(en1), int'(clr1), int'(val1), int'(wr1), int'(done1),
                int'(busy1), int'(x1), int'(w1), int'(t1));
    end
  end

  // Stimulus
  initial begin
    int gap, wid, rst_at;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0; stall0 = 1'b0; stall1 = 1'b0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    // single start pulse, full pass
    repeat (2) cycle_drive(0, 1'b0);
    cycle_drive(0, 1'b1);
    repeat (370) cycle_drive(0, 1'b0);
    // start held through a pass and into the idle cycle after done
    repeat (365 + $urandom_range(0, 40)) cycle_drive(0, 1'b1);
    repeat (380) cycle_drive(0, 1'b0);
    // reset at T0+100, then an immediate fresh pass
    cycle_drive(0, 1'b1);
    repeat (100) cycle_drive(0, 1'b0);
    do_reset(0);
    cycle_drive(0, 1'b1);
    repeat (370) cycle_drive(0, 1'b0);
`ifdef LOCAL_CTRL_STALL_EN
    // stall for 5 cycles in NEXT after neuron 4
    plan_sn[0] = 4; plan_len[0] = 5;
    cycle_drive(0, 1'b1);
    repeat (390) cycle_drive(0, 1'b0);
`endif
    // random start widths, one pass with a random mid-pass reset
    for (int it = 0; it < 3; it++) begin
      gap    = $urandom_range(0, 5);
      wid    = $urandom_range(1, 400);
      rst_at = (it == 1) ? $urandom_range(20, 340) : -1;
      repeat (gap) cycle_drive(0, 1'b0);
      for (int i = 0; i < wid; i++) begin
        if (i == rst_at) do_reset(0);
        else cycle_drive(0, 1'b1);
      end
      repeat (380) cycle_drive(0, 1'b0);
    end
    // minimal configuration: random pulses, held starts, occasional reset
    for (int it = 0; it < 20; it++) begin
      gap    = $urandom_range(0, 3);
      wid    = $urandom_range(1, 12);
      rst_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, wid - 1) : -1;
      repeat (gap) cycle_drive(1, 1'b0);
      for (int i = 0; i < wid; i++) begin
        if (i == rst_at) do_reset(1);
        else cycle_drive(1, 1'b1);
      end
      repeat (8) cycle_drive(1, 1'b0);
    end
    repeat (5) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 6; k++)
        while (evq[d][k].size() > 0) begin
          chk(d, {kname(k), "_leftover"}, 1'b0, -1, evq[d][k][0].c);
          void'(evq[d][k].pop_front());
        end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
